// File: rtl/io_router_pkg.sv
// Shared types and helpers for the IO port router and its address matcher.
package io_router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ACTIVE,
    COMPLETE,
    GAP
  } state_t;

  typedef logic [15:0] port_t;

  localparam port_t OPEN_BUS_DEFAULT = 16'hFFFF;

  // CPU word address [19:1] to a byte port; bits [19:16] are not decoded.
  function automatic port_t port_of(input logic [19:1] addr);
    return {addr[15:1], 1'b0};
  endfunction

  // Port bit 0 never takes part in the compare; a zero mask disables the window.
  function automatic logic window_hit(input port_t port, input port_t base, input port_t mask);
    return (mask != '0) && (((port ^ base) & mask & 16'hFFFE) == '0);
  endfunction

endpackage

// File: rtl/io_port_match.sv
// Combinational window matcher: finds the lowest-index device whose base/mask
// window contains the latched port.
module io_port_match
  import io_router_pkg::*;
#(
  parameter int                    NUM_DEV  = 16,
  parameter int                    IDX_W    = 4,
  parameter logic [NUM_DEV*16-1:0] DEV_BASE = '0,
  parameter logic [NUM_DEV*16-1:0] DEV_MASK = '0
) (
  input  logic [15:0]      port,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (window_hit(port, DEV_BASE[i*16 +: 16], DEV_MASK[i*16 +: 16])) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/io_port_router.sv
// Registered IO port router: decodes CPU IO cycles onto one-hot device strobes
// and always completes the cycle. Optional trace outputs: IO_ROUTER_TRACE_EN.
module io_port_router
  import io_router_pkg::*;
#(
  parameter int                    NUM_DEV  = 16,
  parameter logic [NUM_DEV*16-1:0] DEV_BASE = '0,
  parameter logic [NUM_DEV*16-1:0] DEV_MASK = '0,
  parameter int                    TIMEOUT  = 15,
  parameter logic [15:0]           OPEN_BUS = OPEN_BUS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    d_io,
  input  logic                    data_m_access,
  input  logic [19:1]             data_m_addr,
  output logic                    data_m_ack,
  output logic [15:0]             data_m_data_in,
  output logic [NUM_DEV-1:0]      dev_sel,
  input  logic [NUM_DEV-1:0]      dev_ack,
  input  logic [NUM_DEV*16-1:0]   dev_data,
  output logic                    busy,
  output logic                    timeout_pulse
`ifdef IO_ROUTER_TRACE_EN
  ,
  output logic [15:0]             last_miss_port,
  output logic [15:0]             miss_count
`endif
);

  localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  state_t             state_q;
  state_t             state_d;
  logic [15:0]        port_p0;
  logic [IDX_W-1:0]   win_p0;
  logic [CNT_W-1:0]   cnt_p0;

  logic               hit;
  logic [IDX_W-1:0]   match_idx;
  logic               start;
  logic               win_ack;
  logic               tmo;
  logic [15:0]        win_data;

  logic [NUM_DEV-1:0] sel_nxt;
  logic               ack_nxt;
  logic               pulse_nxt;
  logic [15:0]        rdata_nxt;

  assign start    = data_m_access && d_io;
  assign win_ack  = dev_ack[win_p0];
  assign win_data = dev_data[int'(win_p0)*16 +: 16];
  assign tmo      = (cnt_p0 == CNT_W'(TIMEOUT - 1));

  io_port_match #(
    .NUM_DEV  (NUM_DEV),
    .IDX_W    (IDX_W),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK)
  ) u_match (
    .port (port_p0),
    .hit  (hit),
    .idx  (match_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = DECODE;
      DECODE:   state_d = hit ? ACTIVE : COMPLETE;
      ACTIVE:   if (win_ack || tmo) state_d = COMPLETE;
      COMPLETE: state_d = GAP;
      GAP:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are registered: these are the values they take at the next edge.
  // An ack from the winner beats a timeout landing in the same cycle.
  always_comb begin
    busy      = (state_q != IDLE);
    sel_nxt   = '0;
    ack_nxt   = 1'b0;
    pulse_nxt = 1'b0;
    rdata_nxt = data_m_data_in;
    unique case (state_q)
      DECODE: begin
        if (hit) begin
          sel_nxt = NUM_DEV'(1) << match_idx;
        end else begin
          ack_nxt   = 1'b1;
          rdata_nxt = OPEN_BUS;
        end
      end
      ACTIVE: begin
        if (win_ack) begin
          ack_nxt   = 1'b1;
          rdata_nxt = win_data;
        end else if (tmo) begin
          ack_nxt   = 1'b1;
          pulse_nxt = 1'b1;
          rdata_nxt = OPEN_BUS;
        end else begin
          sel_nxt = dev_sel;
        end
      end
      default: ;
    endcase
  end

  // Stage p0: request capture; the port is frozen for the whole transaction.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      port_p0 <= port_of(data_m_addr);
    end
    if (state_q == DECODE) begin
      win_p0 <= match_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dev_sel        <= '0;
      data_m_ack     <= 1'b0;
      timeout_pulse  <= 1'b0;
      data_m_data_in <= '0;
      cnt_p0         <= '0;
    end else begin
      dev_sel        <= sel_nxt;
      data_m_ack     <= ack_nxt;
      timeout_pulse  <= pulse_nxt;
      data_m_data_in <= rdata_nxt;
      cnt_p0         <= (state_q == ACTIVE) ? CNT_W'(cnt_p0 + 1'b1) : '0;
    end
  end

`ifdef IO_ROUTER_TRACE_EN
  logic miss_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign miss_nxt = (state_q == DECODE && !hit) || pulse_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_miss_port <= '0;
      miss_count     <= '0;
    end else if (miss_nxt) begin
      last_miss_port <= port_p0;
      miss_count     <= sat_inc(miss_count);
    end
  end
`endif

endmodule
